// File: rtl/logical_unit_arbiter_pkg.sv
// Shared definitions for the logical-unit arbiter: data width, opcode values
// and the arbiter FSM state encoding.
package logical_unit_arbiter_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] OP_NOR = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_e;

endpackage

// File: rtl/logical_unit_arbiter_if.sv
// Request/response bundle between the datapath clients (master) and the
// shared logical-unit arbiter (slave).
interface logical_unit_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   import logical_unit_arbiter_pkg::*;

   logic [NUM_REQ-1:0]        reqValid;
   logic [DATA_W*NUM_REQ-1:0] reqA;
   logic [DATA_W*NUM_REQ-1:0] reqB;
   logic [2*NUM_REQ-1:0]      reqOp;
   logic [NUM_REQ-1:0]        reqReady;
   logic                      rspValid;
   logic                      rspReady;
   logic [DATA_W-1:0]         rspData;
   logic [ID_W-1:0]           rspId;
   logic                      busy;

   modport master (
      output reqValid, reqA, reqB, reqOp, rspReady,
      input  reqReady, rspValid, rspData, rspId, busy
   );

   modport slave (
      input  reqValid, reqA, reqB, reqOp, rspReady,
      output reqReady, rspValid, rspData, rspId, busy
   );

endinterface

// File: rtl/logical_unit_arbiter_lu.sv
// Shared 32-bit bitwise logic unit: NOR, AND, OR, XOR selected by a 2-bit opcode.
module logical_unit
   import logical_unit_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] y
);

   // Opcode decode of the bitwise function
   always_comb begin
      y = {DATA_W{1'b0}};
      case (op)
         OP_NOR:  y = ~(a | b);
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/logical_unit_arbiter_rr.sv
// Combinational round-robin picker: grants the first requester at or above
// ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grantId,
   output logic               anyGrant
);

   int dist_s;
   int best_s;

   // Select the requesting index with the smallest upward distance from ptr
   always_comb begin
      dist_s  = 0;
      best_s  = NUM_REQ;
      grantId = {ID_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         dist_s = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
         if (req[i] && (dist_s < best_s)) begin
            best_s  = dist_s;
            grantId = ID_W'(i);
         end else begin
            best_s  = best_s;
         end
      end
   end

   assign anyGrant = |req;

   // One-hot expansion of the selected index
   always_comb begin
      grant = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = anyGrant && (int'(grantId) == i);
      end
   end

endmodule

// File: rtl/logical_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NUM_REQ clients;
// one operation in flight, IDLE -> EXEC -> RESP per transaction.
module logical_unit_arbiter
   import logical_unit_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rstN,
   logical_unit_arbiter_if.slave bus
);

   state_e              state_r;
   state_e              state_nxt_s;
   logic [ID_W-1:0]     rr_ptr_r;
   logic [ID_W-1:0]     nxt_ptr_s;
   logic [ID_W-1:0]     owner_r;
   logic [DATA_W-1:0]   op_a_r;
   logic [DATA_W-1:0]   op_b_r;
   logic [1:0]          op_r;
   logic [DATA_W-1:0]   lu_y_s;
   logic [DATA_W-1:0]   rsp_data_r;
   logic [ID_W-1:0]     rsp_id_r;
   logic                rsp_valid_r;
   logic                busy_r;
   logic [NUM_REQ-1:0]  grant_s;
   logic [ID_W-1:0]     grant_id_s;
   logic                any_grant_s;
   logic [NUM_REQ-1:0]  ready_s;
   logic                accept_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req      (bus.reqValid),
      .ptr      (rr_ptr_r),
      .grant    (grant_s),
      .grantId  (grant_id_s),
      .anyGrant (any_grant_s)
   );

   logical_unit u_lu (
      .a  (op_a_r),
      .b  (op_b_r),
      .op (op_r),
      .y  (lu_y_s)
   );

   assign accept_s  = (state_r == IDLE) && any_grant_s;
   assign nxt_ptr_s = (int'(grant_id_s) == NUM_REQ - 1) ? {ID_W{1'b0}}
                                                         : grant_id_s + ID_W'(1'b1);

   // FSM state register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and the IDLE-only accept strobe
   always_comb begin
      state_nxt_s = state_r;
      ready_s     = {NUM_REQ{1'b0}};
      case (state_r)
         IDLE: begin
            if (any_grant_s) begin
               state_nxt_s = EXEC;
               ready_s     = grant_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: state_nxt_s = RESP;
         RESP: begin
            if (bus.rspReady) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand capture and round-robin pointer advance on accept
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         op_a_r   <= {DATA_W{1'b0}};
         op_b_r   <= {DATA_W{1'b0}};
         op_r     <= 2'b00;
         owner_r  <= {ID_W{1'b0}};
         rr_ptr_r <= {ID_W{1'b0}};
      end else if (accept_s) begin
         op_a_r   <= bus.reqA[int'(grant_id_s)*DATA_W +: DATA_W];
         op_b_r   <= bus.reqB[int'(grant_id_s)*DATA_W +: DATA_W];
         op_r     <= bus.reqOp[int'(grant_id_s)*2 +: 2];
         owner_r  <= grant_id_s;
         rr_ptr_r <= nxt_ptr_s;
      end
   end

   // Result registration in EXEC and response handshake in RESP
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rsp_data_r  <= {DATA_W{1'b0}};
         rsp_id_r    <= {ID_W{1'b0}};
         rsp_valid_r <= 1'b0;
      end else begin
         case (state_r)
            EXEC: begin
               rsp_data_r  <= lu_y_s;
               rsp_id_r    <= owner_r;
               rsp_valid_r <= 1'b1;
            end
            RESP: begin
               if (bus.rspReady) begin
                  rsp_valid_r <= 1'b0;
               end
            end
            default: rsp_valid_r <= rsp_valid_r;
         endcase
      end
   end

   // Registered busy flag tracking the upcoming state
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != IDLE);
      end
   end

   // Gated by rstN so no grant is offered while reset is held
   assign bus.reqReady = ready_s & {NUM_REQ{rstN}};
   assign bus.rspValid = rsp_valid_r;
   assign bus.rspData  = rsp_data_r;
   assign bus.rspId    = rsp_id_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_logical_unit_arbiter.sv
// Directed bench for logical_unit_arbiter with a transaction-level reference
// model compared on every falling clock edge.
module tb_logical_unit_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic clk  = 1'b0;
   logic rstN = 1'b1;

   always #5 clk = ~clk;

   logical_unit_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

   logical_unit_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one transaction in flight, result visible two cycles after accept
   bit          m_inflight = 1'b0;
   int          m_age      = 0;
   int          m_ptr      = 0;
   logic [31:0] m_pend     = 32'h0;
   int          m_pend_id  = 0;
   logic [31:0] m_data     = 32'h0;
   int          m_id       = 0;

   function automatic logic [31:0] lu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
      case (op)
         2'b00:   return ~(a | b);
         2'b01:   return a & b;
         2'b10:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (bus.reqValid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      g = pick();
      if (rstN && !m_inflight && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         m_inflight <= 1'b0;
         m_age      <= 0;
         m_ptr      <= 0;
         m_data     <= 32'h0;
         m_id       <= 0;
      end else if (!m_inflight) begin
         if (pick() >= 0) begin
            m_inflight <= 1'b1;
            m_age      <= 1;
            m_pend     <= lu_ref(bus.reqA[32*pick() +: 32], bus.reqB[32*pick() +: 32],
                                 bus.reqOp[2*pick() +: 2]);
            m_pend_id  <= pick();
            m_ptr      <= (pick() + 1) % N;
         end
      end else if (m_age == 1) begin
         m_age  <= 2;
         m_data <= m_pend;
         m_id   <= m_pend_id;
      end else if (bus.rspReady) begin
         m_inflight <= 1'b0;
         m_age      <= 0;
      end
   end

   always @(negedge clk) begin
      check("m_reqReady", 32'(bus.reqReady), 32'(exp_ready()));
      check("m_rspValid", 32'(bus.rspValid), 32'(m_inflight && (m_age == 2)));
      check("m_busy",     32'(bus.busy),     32'(m_inflight));
      check("m_rspData",  bus.rspData,       m_data);
      check("m_rspId",    32'(bus.rspId),    32'(m_id));
   end

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
      bus.reqA[32*id +: 32] = a;
      bus.reqB[32*id +: 32] = b;
      bus.reqOp[2*id +: 2]  = op;
      bus.reqValid[id]      = 1'b1;
   endtask

   // Lone request: entered #1 after a rising edge with the DUT idle
   task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp);
      logic [N-1:0] oh;
      oh = '0;
      oh[id] = 1'b1;
      set_req(id, a, b, op);
      bus.rspReady = 1'b1;
      @(negedge clk);
      check("op_ready", 32'(bus.reqReady), 32'(oh));
      @(posedge clk); #1;
      bus.reqValid[id] = 1'b0;
      @(negedge clk);
      check("op_exec_valid", 32'(bus.rspValid), 32'h0);
      @(negedge clk);
      check("op_valid", 32'(bus.rspValid), 32'h1);
      check("op_data",  bus.rspData, exp);
      check("op_id",    32'(bus.rspId), 32'(id));
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int order [5];
      logic [N-1:0] oh;
      order = '{0, 1, 2, 3, 0};

      bus.reqValid = '0;
      bus.reqA     = '0;
      bus.reqB     = '0;
      bus.reqOp    = '0;
      bus.rspReady = 1'b0;
      #1 rstN = 1'b0;
      bus.reqValid = 4'b0101;
      @(negedge clk);
      check("reset_busy",     32'(bus.busy),     32'h0);
      check("reset_rspValid", 32'(bus.rspValid), 32'h0);
      check("reset_rspData",  bus.rspData,       32'h0);
      check("reset_reqReady", 32'(bus.reqReady), 32'h0);
      @(posedge clk); #1;
      bus.reqValid = '0;
      rstN = 1'b1;

      run_op(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b01, 32'h00F0_00F0);

      run_op(2, 32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 32'h0000_AAAA);
      run_op(2, 32'hAAAA_5555, 32'hFFFF_0000, 2'b01, 32'hAAAA_0000);
      run_op(2, 32'hAAAA_5555, 32'hFFFF_0000, 2'b10, 32'hFFFF_5555);
      run_op(2, 32'hAAAA_5555, 32'hFFFF_0000, 2'b11, 32'h5555_5555);

      // Pointer now at 3: requesters 0 and 3 together
      set_req(0, 32'h1111_0000, 32'h0000_1111, 2'b10);
      set_req(3, 32'h1234_5678, 32'hFFFF_FFFF, 2'b11);
      bus.rspReady = 1'b1;
      @(negedge clk);
      check("wrap_first", 32'(bus.reqReady), 32'h8);
      @(posedge clk); #1;
      bus.reqValid[3] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wrap_first_id",   32'(bus.rspId), 32'h3);
      check("wrap_first_data", bus.rspData,    32'hEDCB_A987);
      @(posedge clk); #1;
      @(negedge clk);
      check("wrap_second", 32'(bus.reqReady), 32'h1);
      @(posedge clk); #1;
      bus.reqValid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wrap_second_data", bus.rspData, 32'h1111_1111);
      @(posedge clk); #1;

      // Backpressure with requester 2 waiting behind requester 1
      bus.rspReady = 1'b0;
      set_req(1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 2'b01);
      set_req(2, 32'hCAFE_0000, 32'h0000_F00D, 2'b10);
      @(negedge clk);
      check("bp_grant", 32'(bus.reqReady), 32'h2);
      @(posedge clk); #1;
      bus.reqValid[1] = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_valid", 32'(bus.rspValid), 32'h1);
         check("bp_data",  bus.rspData,       32'h0E0D_0E0F);
         check("bp_id",    32'(bus.rspId),    32'h1);
         check("bp_ready", 32'(bus.reqReady), 32'h0);
      end
      bus.rspReady = 1'b1;
      @(negedge clk);
      check("bp_idle_busy",  32'(bus.busy),     32'h0);
      check("bp_next_grant", 32'(bus.reqReady), 32'h4);
      @(posedge clk); #1;
      bus.reqValid[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp_next_data", bus.rspData,    32'hCAFE_F00D);
      check("bp_next_id",   32'(bus.rspId), 32'h2);
      @(posedge clk); #1;

      // Asynchronous reset while an operation sits in EXEC
      set_req(1, 32'h0000_FFFF, 32'h00FF_00FF, 2'b11);
      @(posedge clk); #1;
      bus.reqValid[1] = 1'b0;
      #2;
      bus.reqValid[3] = 1'b1;
      rstN = 1'b0;
      #1;
      check("arst_busy",     32'(bus.busy),     32'h0);
      check("arst_rspValid", 32'(bus.rspValid), 32'h0);
      check("arst_reqReady", 32'(bus.reqReady), 32'h0);
      check("arst_rspData",  bus.rspData,       32'h0);
      @(posedge clk); #1;
      bus.reqValid = '0;
      rstN = 1'b1;

      // All requesters continuously valid: order 0,1,2,3,0, one grant per 3 cycles
      for (int i = 0; i < N; i++) begin
         set_req(i, 32'h0101_0101 * 32'(i + 1), 32'hFFFF_FFFF, 2'b01);
      end
      bus.rspReady = 1'b1;
      for (int g = 0; g < 5; g++) begin
         oh = '0;
         oh[order[g]] = 1'b1;
         @(negedge clk);
         check("rr_grant", 32'(bus.reqReady), 32'(oh));
         @(negedge clk);
         @(negedge clk);
         check("rr_id",   32'(bus.rspId), 32'(order[g]));
         check("rr_data", bus.rspData,    32'h0101_0101 * 32'(order[g] + 1));
      end
      bus.reqValid = '0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
